// File: rtl/mem_sort_pkg.sv
// Shared types and helpers for the in-place memory bubble-sort engine.
// Build option: SORT_EARLY_EXIT_EN (consumed by mem_sort_engine).
package mem_sort_pkg;
  localparam int SWAP_CNT_W = 16;
  // Element indices up to 1023 need 10 bits; one spare keeps j+1 unambiguous.
  localparam int IDX_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_A,
    WR_B,
    DONE
  } state_t;

  function automatic logic [63:0] addr_of(input logic [63:0] base,
                                          input logic [63:0] stride,
                                          input logic [IDX_W-1:0] idx);
    return base + 64'(idx) * stride;
  endfunction
endpackage

// File: rtl/sort_index_ctr.sv
// Pass (i) and compare (j) counters for the bubble sort, with the
// last-compare-of-pass and last-pass flags used by the advance decision.
module sort_index_ctr
  import mem_sort_pkg::*;
#(
  parameter int N_ELEMS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_j,
  output logic             o_last_cmp,
  output logic             o_last_pass
);
  localparam int LAST = (N_ELEMS >= 2) ? N_ELEMS - 2 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_advance) begin
      if (!o_last_cmp) begin
        r_j <= r_j + IDX_W'(1);
      end else if (!o_last_pass) begin
        r_i <= r_i + IDX_W'(1);
        r_j <= '0;
      end
    end
  end

  assign o_j         = r_j;
  assign o_last_cmp  = (r_j == LAST_IDX - r_i);
  assign o_last_pass = (r_i == LAST_IDX);
endmodule

// File: rtl/mem_sort_engine.sv
// In-place ascending bubble sort over a strided block of datamemory words.
// Build option: define SORT_EARLY_EXIT_EN to stop after a pass with no swaps.
module mem_sort_engine
  import mem_sort_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          N_ELEMS   = 10,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [63:0] STRIDE    = 64'd8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_count,
  output logic [ADDR_W-1:0]     address,
  output logic                  memoryread,
  output logic                  memorywrite,
  output logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W-1:0]     read_data
);
  localparam bit SHORT = (N_ELEMS < 2);

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_W-1:0]       r_a;
  logic [DATA_W-1:0]       r_b;
  logic [SWAP_CNT_W-1:0]   r_swap_count;
  logic [IDX_W-1:0]        w_j;
  logic [IDX_W-1:0]        w_j1;
  logic                    w_last_cmp;
  logic                    w_last_pass;
  logic                    w_adv;
  logic                    w_start_ok;
  logic                    w_gt;
  logic                    w_early;
  logic                    w_stop;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    return (&v) ? v : v + SWAP_CNT_W'(1);
  endfunction

  sort_index_ctr #(.N_ELEMS(N_ELEMS)) u_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_start_ok),
    .i_advance  (w_adv),
    .o_j        (w_j),
    .o_last_cmp (w_last_cmp),
    .o_last_pass(w_last_pass)
  );

  assign w_j1 = w_j + IDX_W'(1);
  assign w_gt = (r_a > read_data);

`ifdef SORT_EARLY_EXIT_EN
  logic r_swapped;

  // A WR_B in the deciding cycle counts as a swap in the pass being closed.
  assign w_early = w_last_cmp && !(r_swapped || (r_state == WR_B));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_swapped <= 1'b0;
    end else if (w_start_ok || (w_adv && w_last_cmp)) begin
      r_swapped <= 1'b0;
    end else if (r_state == WR_B) begin
      r_swapped <= 1'b1;
    end
  end
`else
  assign w_early = 1'b0;
`endif

  assign w_stop = (w_last_cmp && w_last_pass) || w_early;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_swap_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_swap_count <= '0;
      end else if (r_state == WR_B) begin
        r_swap_count <= sat_inc(r_swap_count);
      end
    end
  end

  // Operand registers carry data only; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (r_state == RD_A) r_a <= read_data;
    if (r_state == RD_B) r_b <= read_data;
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    memoryread  = 1'b0;
    memorywrite = 1'b0;
    address     = '0;
    write_data  = '0;
    w_adv       = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = SHORT ? DONE : RD_A;
        end
      end
      RD_A: begin
        busy       = 1'b1;
        memoryread = 1'b1;
        address    = ADDR_W'(addr_of(BASE_ADDR, STRIDE, w_j));
        w_next     = RD_B;
      end
      RD_B: begin
        busy       = 1'b1;
        memoryread = 1'b1;
        address    = ADDR_W'(addr_of(BASE_ADDR, STRIDE, w_j1));
        if (w_gt) begin
          w_next = WR_A;
        end else begin
          w_adv  = 1'b1;
          w_next = w_stop ? DONE : RD_A;
        end
      end
      WR_A: begin
        busy        = 1'b1;
        memorywrite = 1'b1;
        address     = ADDR_W'(addr_of(BASE_ADDR, STRIDE, w_j));
        write_data  = r_b;
        w_next      = WR_B;
      end
      WR_B: begin
        busy        = 1'b1;
        memorywrite = 1'b1;
        address     = ADDR_W'(addr_of(BASE_ADDR, STRIDE, w_j1));
        write_data  = r_a;
        w_adv       = 1'b1;
        w_next      = w_stop ? DONE : RD_A;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign swap_count = r_swap_count;
endmodule

// File: tb/tb_mem_sort_engine.sv
// Bench for mem_sort_engine: a 10-word memory model plus a reference sort,
// and a second single-element instance.
module tb_mem_sort_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, memoryread, memorywrite;
  logic [15:0] swap_count;
  logic [63:0] address, write_data, read_data;
  logic [63:0] mem [0:15];

  logic        start1 = 1'b0;
  logic        busy1, done1, rd1, wr1;
  logic [15:0] sc1;
  logic [63:0] addr1, wd1;
  logic [63:0] rdata1 = 64'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign read_data = memoryread ? mem[address[6:3]] : 64'd0;

  mem_sort_engine #(.N_ELEMS(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .swap_count(swap_count), .address(address), .memoryread(memoryread),
    .memorywrite(memorywrite), .write_data(write_data), .read_data(read_data)
  );

  mem_sort_engine #(.N_ELEMS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
    .swap_count(sc1), .address(addr1), .memoryread(rd1),
    .memorywrite(wr1), .write_data(wd1), .read_data(rdata1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a sort on the current memory image and checks it against the
  // reference: sorted contents, swaps = inversions, latency from compares.
  task automatic run_sort(input string tag, input bit extra_starts);
    logic [63:0] ref_q[$];
    int inv, maxleft, left, passes, cmps, exp_lat;
    int cyc, lat, wr, both, dn;
    ref_q = {};
    inv = 0;
    maxleft = 0;
    for (int a = 0; a < 10; a++) begin
      ref_q.push_back(mem[a]);
      left = 0;
      for (int b = 0; b < a; b++) if (mem[b] > mem[a]) left++;
      inv += left;
      if (left > maxleft) maxleft = left;
    end
    ref_q.sort();
    passes = 9;
`ifdef SORT_EARLY_EXIT_EN
    if (maxleft + 1 < 9) passes = maxleft + 1;
`endif
    cmps = 0;
    for (int k = 0; k < passes; k++) cmps += 9 - k;
    exp_lat = 2 * cmps + 2 * inv + 1;

    cyc = 0; lat = -1; wr = 0; both = 0; dn = 0;
    start = 1'b1;
    while (cyc < 400 && (lat < 0 || cyc < lat + 3)) begin
      @(negedge clk);
      cyc++;
      start = extra_starts && (cyc == 3 || cyc == 50);
      if (memoryread && memorywrite) both++;
      if (memorywrite) begin
        wr++;
        mem[address[6:3]] = write_data;
      end
      if (done) begin
        dn++;
        if (lat < 0) lat = cyc;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " swap_count"}, 64'(swap_count), 64'(inv));
    check({tag, " write cycles"}, 64'(wr), 64'(2 * inv));
    check({tag, " rd+wr overlap"}, 64'(both), 64'd0);
    check({tag, " done pulses"}, 64'(dn), 64'd1);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    for (int k = 0; k < 10; k++) check($sformatf("%s mem[%0d]", tag, k), mem[k], ref_q[k]);
  endtask

  initial begin
    logic [63:0] dup_vals [0:9];
    int cyc, found, prev_wr;
    int rcnt, wcnt, lat1;
    for (int k = 0; k < 16; k++) mem[k] = 64'd0;
    dup_vals = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 64'd3,
                 64'd7, 64'd5, 64'd1, 64'd9, 64'd2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst memoryread", 64'(memoryread), 64'd0);
    check("rst memorywrite", 64'(memorywrite), 64'd0);
    check("rst address", address, 64'd0);
    check("rst write_data", write_data, 64'd0);
    check("rst swap_count", 64'(swap_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reverse order
    for (int k = 0; k < 10; k++) mem[k] = 64'(10 - k);
    run_sort("reverse", 1'b0);

    // Already sorted
    for (int k = 0; k < 10; k++) mem[k] = 64'(k + 1);
    run_sort("sorted", 1'b0);

    // Duplicates and extremes
    for (int k = 0; k < 10; k++) mem[k] = dup_vals[k];
    run_sort("dups", 1'b0);
    check("dups max at addr 72", mem[9], 64'hFFFF_FFFF_FFFF_FFFF);

    // Start pulses while busy
    for (int k = 0; k < 10; k++) mem[k] = 64'(10 - k);
    run_sort("start-busy", 1'b1);

    // Randomised contents: narrow range for duplicates, then full width
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 10; k++)
        mem[k] = (t == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
      run_sort($sformatf("random%0d", t), 1'b0);
    end

    // Reset during a WR_B
    for (int k = 0; k < 10; k++) mem[k] = 64'(10 - k);
    start = 1'b1;
    cyc = 0; found = 0; prev_wr = 0;
    while (cyc < 400 && found == 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (memorywrite && prev_wr != 0 && cyc > 30) begin
        found = 1;
      end else begin
        if (memorywrite) mem[address[6:3]] = write_data;
        prev_wr = memorywrite ? 1 : 0;
      end
    end
    check("wr_b reached", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort memorywrite", 64'(memorywrite), 64'd0);
    check("abort swap_count", 64'(swap_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_sort("after-reset", 1'b0);

    // Single-element instance
    rcnt = 0; wcnt = 0; lat1 = -1;
    start1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (rd1) rcnt++;
      if (wr1) wcnt++;
      if (done1 && lat1 < 0) lat1 = c;
    end
    check("n1 latency", 64'(lat1), 64'd1);
    check("n1 reads", 64'(rcnt), 64'd0);
    check("n1 writes", 64'(wcnt), 64'd0);
    check("n1 swap_count", 64'(sc1), 64'd0);
    check("n1 busy", 64'(busy1), 64'd0);
    check("n1 address", addr1, 64'd0);
    check("n1 write_data", wd1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_sort_engine.md
Name: mem_sort_engine

Overview:
- Hardware bubble-sort sequencer that sits directly upstream of datamemory and drives its single read/write port.
- Sorts N_ELEMS consecutive 64-bit words in place, ascending. The words start at BASE_ADDR and are spaced STRIDE bytes apart.
- Replaces the software/bench-driven sort loop.
- Started by a one-cycle strobe; reports completion with a done pulse and a swap count.

Parameters:
- DATA_W, 64, word width; matches the datamemory data port.
- ADDR_W, 64, address width; matches the datamemory address port.
- N_ELEMS, 10, number of words to sort; legal range 0..1024.
- BASE_ADDR, 0, byte address of element 0.
- STRIDE, 8, byte distance between consecutive elements.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe; begins a sort when idle.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the sort completes.
- swap_count  out  16  number of swaps performed in the last/current sort.
- address  out  ADDR_W  datamemory byte address.
- memoryread  out  1  datamemory read enable.
- memorywrite  out  1  datamemory write enable.
- write_data  out  DATA_W  datamemory write data.
- read_data  in  DATA_W  datamemory read data; combinational from address while memoryread=1.

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - busy, done, memoryread and memorywrite go to 0.
  - address, write_data and swap_count go to 0.
  - Reset mid-sort aborts immediately. Memory is left partially sorted but each word is intact, because writes commit only on a clock edge.
- Memory timing:
  - Each access takes one cycle.
  - Read: the engine drives address with memoryread=1 and captures read_data at the end of that cycle.
  - Write: address, write_data and memorywrite=1 are held for one cycle and commit on the closing edge.
  - memoryread and memorywrite are never both high.
- Loop counters:
  - pass i runs 0..N_ELEMS-2.
  - index j runs 0..N_ELEMS-2-i.
  - Element address = BASE_ADDR + j*STRIDE, computed at ADDR_W width with wrap-around.
- States:
  - IDLE: outputs quiet. On start=1, go to RD_A with i=0, j=0, swap_count cleared and busy set. If N_ELEMS<2, go straight to DONE with no memory access.
  - RD_A: read element j into reg_a.
  - RD_B: read element j+1 into reg_b. If reg_a > reg_b (unsigned), go to WR_A; otherwise go to ADV.
  - WR_A: write reg_b to element j.
  - WR_B: write reg_a to element j+1, increment swap_count (saturates at 16'hFFFF), then go to ADV.
  - ADV: combinational decision, taken in the same cycle as the last RD_B or WR_B; it has no cycle of its own.
    - If j < N_ELEMS-2-i: j++ and go to RD_A.
    - Else if i < N_ELEMS-2: i++, j=0, go to RD_A.
    - Otherwise go to DONE.
  - DONE: one cycle. done=1, busy drops to 0 in the same cycle, then return to IDLE.
- Ordering: equal values are not swapped, so the sort is stable.
- Latency: from start to the done cycle = 2*compares + 2*swaps + 1 cycles, with compares = N(N-1)/2 (45 for N=10).
- start while busy or in DONE is ignored. start in the cycle after DONE is accepted.
- swap_count holds its value after done until the next accepted start.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - A per-pass swapped flag is cleared at the start of each pass.
  - If a pass completes with no swaps, go to DONE instead of starting the next pass.
  - An already-sorted array takes N-1 compares plus 1 cycle, i.e. 2*(N-1)+1 cycles.
- Undefined: all N(N-1)/2 compares are always executed.

Decomposition:
- Package mem_sort_pkg holds:
  - the state enum (IDLE, RD_A, RD_B, WR_A, WR_B, DONE);
  - the SWAP_CNT_W=16 constant;
  - an address-of-index helper function (BASE_ADDR + idx*STRIDE).
- One sub-module, sort_index_ctr, holds the i/j counters, the last-compare-of-pass / last-pass flags and the advance logic. The top level keeps the FSM, data registers and memory port.

Test Plan:
- Reverse-order input: memory preloaded 10,9,...,1; start → final memory 1..10, swap_count=45, done asserted 181 cycles after start (90 compare + 90 swap + 1).
- Already sorted: 1..10; start → no memorywrite ever asserted, swap_count=0, done at cycle 91. With SORT_EARLY_EXIT_EN, done at cycle 19.
- Duplicates and extremes: 5,0xFFFF_FFFF_FFFF_FFFF,5,0,... → unsigned ascending order, equal 5s never written, max value ends at address 72.
- Start while busy: pulse start again at cycles 3 and 50 → ignored, single done pulse, result identical to a single start.
- Reset mid-sort: drop reset_n for one cycle during a WR_B → busy, memorywrite and swap_count are 0 immediately. A subsequent start fully sorts the now partially-sorted data.
- N_ELEMS=1: start → done the next cycle, memoryread and memorywrite never asserted, swap_count=0.
